exc_pipe: RTL and testbench

EXC_PIPE -- requirements
Module: exc_pipe

---
 rtl/exc_pipe.sv | 151 +++++++++++++++
 tb/tb_exc_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_pipe.sv
// exc_pipe: tracks the exception state of the instructions in flight through
// NSTAGE pipeline stages. It records the first exception each instruction
// sees and reports it (cause and return PC) when the instruction leaves the
// last stage.
//
// Handshake: there is no valid/ready pair. valid_in qualifies the entry
// offered to stage 0. stall[i] holds stage i. The caller keeps stall
// monotonic: stall[i] implies stall[j] for every j < i. exc_req is a
// one-cycle, registered pulse that goes out together with cause_out and
// epc_out.
module exc_pipe #(
    parameter int NSTAGE = 4,
    parameter int XLEN   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [XLEN-1:0]       pc_in,
    input  logic                  bd_in,
    input  logic [NSTAGE-1:0]     exc_vld,
    input  logic [5*NSTAGE-1:0]   exc_code,
    input  logic [NSTAGE-1:0]     stall,
    input  logic                  flush,
    output logic                  exc_req,
    output logic [31:0]           cause_out,
    output logic [XLEN-1:0]       epc_out,
    output logic                  pend
);

    // Per-stage state registers
    logic [NSTAGE-1:0]            valid_q, valid_d;
    logic [NSTAGE-1:0][XLEN-1:0]  pc_q,    pc_d;
    logic [NSTAGE-1:0]            bd_q,    bd_d;
    logic [NSTAGE-1:0]            exc_q,   exc_d;
    logic [NSTAGE-1:0][4:0]       code_q,  code_d;

    // Each stage's entry with this cycle's detection folded in
    logic [NSTAGE-1:0]            m_exc;
    logic [NSTAGE-1:0][4:0]       m_code;

    // Commit path and output registers
    logic                         commit;
    logic [XLEN-1:0]              epc_d;
    logic [31:0]                  cause_d;
    logic                         exc_req_q;
    logic [31:0]                  cause_q;
    logic [XLEN-1:0]              epc_q;

    // Fold this cycle's detection into each stage. The first exception wins,
    // and an invalid stage ignores exc_vld.
    always_comb begin
        m_exc  = '0;
        m_code = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            m_exc[i] = exc_q[i] | (valid_q[i] & exc_vld[i]);
            if (!exc_q[i] && valid_q[i] && exc_vld[i]) begin
                m_code[i] = exc_code[5*i +: 5];
            end else begin
                m_code[i] = code_q[i];
            end
        end
    end

    // The last stage commits when it is valid, carries an exception and is
    // free to advance.
    always_comb begin
        commit  = valid_q[NSTAGE-1] & m_exc[NSTAGE-1] & ~stall[NSTAGE-1];
        epc_d   = bd_q[NSTAGE-1] ? (pc_q[NSTAGE-1] - XLEN'(4)) : pc_q[NSTAGE-1];
        cause_d = {bd_q[NSTAGE-1], 24'b0, m_code[NSTAGE-1], 2'b0};
    end

    // Next stage state. By default a stage holds and writes its merged entry
    // back, so a detection made during a stall is kept. A stage loads from
    // upstream when it can advance, and takes a bubble when upstream is held.
    // A flush or a commit drops every valid.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        bd_d    = bd_q;
        exc_d   = m_exc;
        code_d  = m_code;
        if (!stall[0]) begin
            valid_d[0] = valid_in;
            pc_d[0]    = pc_in;
            bd_d[0]    = bd_in;
            exc_d[0]   = 1'b0;
            code_d[0]  = 5'd0;
        end
        for (int i = 1; i < NSTAGE; i++) begin
            if (!stall[i]) begin
                if (stall[i-1]) begin
                    valid_d[i] = 1'b0;
                    exc_d[i]   = 1'b0;
                    code_d[i]  = 5'd0;
                end else begin
                    valid_d[i] = valid_q[i-1];
                    pc_d[i]    = pc_q[i-1];
                    bd_d[i]    = bd_q[i-1];
                    exc_d[i]   = m_exc[i-1];
                    code_d[i]  = m_code[i-1];
                end
            end
        end
        if (flush || commit) begin
            valid_d = '0;
        end
    end

    // Stage registers; reset clears every field
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            pc_q    <= '0;
            bd_q    <= '0;
            exc_q   <= '0;
            code_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            bd_q    <= bd_d;
            exc_q   <= exc_d;
            code_q  <= code_d;
        end
    end

    // Commit reporting. exc_req pulses for one cycle, and cause/epc hold
    // their values until the next commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_req_q <= 1'b0;
            cause_q   <= '0;
            epc_q     <= '0;
        end else begin
            exc_req_q <= commit;
            if (commit) begin
                cause_q <= cause_d;
                epc_q   <= epc_d;
            end
        end
    end

    // A recorded exception is pending in some valid stage (registered state only)
    always_comb begin
        pend = |(valid_q & exc_q);
    end

    assign exc_req   = exc_req_q;
    assign cause_out = cause_q;
    assign epc_out   = epc_q;

endmodule

// File: tb/tb_exc_pipe.sv
// Directed testbench for exc_pipe with NSTAGE=4 and XLEN=32. Inputs change
// 1 time unit after each rising edge, and outputs are checked at that point.
module tb_exc_pipe;

  localparam int NSTAGE = 4;
  localparam int XLEN   = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                 valid_in;
  logic [XLEN-1:0]      pc_in;
  logic                 bd_in;
  logic [NSTAGE-1:0]    exc_vld;
  logic [5*NSTAGE-1:0]  exc_code;
  logic [NSTAGE-1:0]    stall;
  logic                 flush;
  logic                 exc_req;
  logic [31:0]          cause_out;
  logic [XLEN-1:0]      epc_out;
  logic                 pend;

  int checks = 0;
  int errors = 0;

  exc_pipe #(.NSTAGE(NSTAGE), .XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .pc_in     (pc_in),
    .bd_in     (bd_in),
    .exc_vld   (exc_vld),
    .exc_code  (exc_code),
    .stall     (stall),
    .flush     (flush),
    .exc_req   (exc_req),
    .cause_out (cause_out),
    .epc_out   (epc_out),
    .pend      (pend)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0;
    pc_in    = '0;
    bd_in    = 1'b0;
    exc_vld  = '0;
    exc_code = '0;
    stall    = '0;
    flush    = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic bd);
    valid_in = 1'b1;
    pc_in    = pc;
    bd_in    = bd;
    tick();
    valid_in = 1'b0;
    pc_in    = '0;
    bd_in    = 1'b0;
  endtask

  task automatic detect(input int stage, input logic [4:0] code);
    exc_vld                = '0;
    exc_code               = '0;
    exc_vld[stage]         = 1'b1;
    exc_code[5*stage +: 5] = code;
  endtask

  task automatic no_detect();
    exc_vld  = '0;
    exc_code = '0;
  endtask

  // comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #2;
    check("rst_exc_req", {31'b0, exc_req}, 32'h0);
    check("rst_pend",    {31'b0, pend},    32'h0);
    check("rst_cause",   cause_out,        32'h0);
    check("rst_epc",     epc_out,          32'h0);
    #10 reset = 1'b1;
    tick();

    // An exception detected in stage 1 commits after the instruction leaves stage 3
    issue(32'h0000_3000, 1'b0);           // in stage 0
    tick();                               // in stage 1
    detect(1, 5'd10);
    check("t1_pend_before", {31'b0, pend}, 32'h0);
    tick();                               // in stage 2 with the exception recorded
    no_detect();
    check("t1_pend_s2", {31'b0, pend},    32'h1);
    check("t1_req_s2",  {31'b0, exc_req}, 32'h0);
    tick();                               // in stage 3
    check("t1_pend_s3", {31'b0, pend},    32'h1);
    check("t1_req_s3",  {31'b0, exc_req}, 32'h0);
    tick();                               // committed
    check("t1_req",   {31'b0, exc_req}, 32'h1);
    check("t1_cause", cause_out,        32'h0000_0028);
    check("t1_epc",   epc_out,          32'h0000_3000);
    check("t1_pend_after", {31'b0, pend}, 32'h0);
    tick();
    check("t1_req_pulse", {31'b0, exc_req}, 32'h0);
    check("t1_cause_hold", cause_out,       32'h0000_0028);

    // Branch-delay slot: the first exception wins over a later one
    issue(32'h0000_3004, 1'b1);           // stage 0
    tick();                               // stage 1
    tick();                               // stage 2
    detect(2, 5'd12);
    tick();                               // stage 3, code 12 recorded
    detect(3, 5'd4);
    check("t2_pend", {31'b0, pend}, 32'h1);
    tick();
    no_detect();
    check("t2_req",   {31'b0, exc_req}, 32'h1);
    check("t2_cause", cause_out,        32'h8000_0030);
    check("t2_epc",   epc_out,          32'h0000_3000);
    tick();

    // A detection during a stall is kept; stage 3 takes bubbles meanwhile
    issue(32'h0000_4000, 1'b0);           // stage 0
    tick();                               // stage 1
    tick();                               // stage 2
    stall = 4'b0111;
    detect(2, 5'd13);
    tick();
    no_detect();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_pend_stall%0d", i), {31'b0, pend},    32'h1);
      check($sformatf("t3_req_stall%0d", i),  {31'b0, exc_req}, 32'h0);
      if (i < 2) tick();
    end
    stall = 4'b0000;
    tick();                               // first edge after release: moves to stage 3
    check("t3_req_rel1",  {31'b0, exc_req}, 32'h0);
    check("t3_pend_rel1", {31'b0, pend},    32'h1);
    tick();                               // second edge after release: commit
    check("t3_req",   {31'b0, exc_req}, 32'h1);
    check("t3_cause", cause_out,        32'h0000_0034);
    check("t3_epc",   epc_out,          32'h0000_4000);
    tick();

    // A flush arriving while stage 3 commits still reports the commit
    issue(32'h0000_5000, 1'b0);           // stage 0
    tick();                               // stage 1
    detect(1, 5'd7);
    tick();                               // stage 2
    no_detect();
    tick();                               // stage 3
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_req",   {31'b0, exc_req}, 32'h1);
    check("t4_cause", cause_out,        32'h0000_001C);
    check("t4_epc",   epc_out,          32'h0000_5000);
    check("t4_pend",  {31'b0, pend},    32'h0);

    // A flush with no committing exception discards the pending one
    issue(32'h0000_6000, 1'b0);           // stage 0
    detect(0, 5'd3);
    tick();                               // stage 1, exception recorded
    no_detect();
    check("t4b_pend_before", {31'b0, pend}, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4b_req",  {31'b0, exc_req}, 32'h0);
    check("t4b_pend", {31'b0, pend},    32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t4b_req_later%0d", i), {31'b0, exc_req}, 32'h0);
    end
    check("t4b_cause_hold", cause_out, 32'h0000_001C);

    // pc=0 in a delay slot wraps; ExcCode 0 is a real exception
    issue(32'h0000_0000, 1'b1);           // stage 0
    detect(0, 5'd0);
    tick();                               // stage 1
    no_detect();
    tick();                               // stage 2
    tick();                               // stage 3
    tick();
    check("t5_req",   {31'b0, exc_req}, 32'h1);
    check("t5_epc",   epc_out,          32'hFFFF_FFFC);
    check("t5_cause", cause_out,        32'h8000_0000);
    tick();

    // Back-to-back excepting instructions: the first commit empties the pipe
    valid_in = 1'b1; pc_in = 32'h0000_7000; bd_in = 1'b0;
    tick();                               // X in stage 0
    pc_in = 32'h0000_7004;
    detect(0, 5'd1);
    tick();                               // X stage 1, Y stage 0
    valid_in = 1'b0; pc_in = '0;
    detect(0, 5'd2);
    tick();                               // X stage 2, Y stage 1
    no_detect();
    tick();                               // X stage 3
    tick();                               // X commits
    check("t6_req",   {31'b0, exc_req}, 32'h1);
    check("t6_cause", cause_out,        32'h0000_0004);
    check("t6_epc",   epc_out,          32'h0000_7000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_req_after%0d", i), {31'b0, exc_req}, 32'h0);
    end
    check("t6_pend", {31'b0, pend}, 32'h0);

    // An asynchronous reset mid-cycle clears everything and cancels the commit
    issue(32'h0000_8000, 1'b0);           // stage 0
    detect(0, 5'd9);
    tick();                               // stage 1
    no_detect();
    tick();                               // stage 2
    tick();                               // stage 3, about to commit
    check("t7_pend_before", {31'b0, pend}, 32'h1);
    #3 reset = 1'b0;
    #1;
    check("t7_pend",    {31'b0, pend},    32'h0);
    check("t7_req",     {31'b0, exc_req}, 32'h0);
    check("t7_cause",   cause_out,        32'h0);
    check("t7_epc",     epc_out,          32'h0);
    tick();
    check("t7_req_cancel", {31'b0, exc_req}, 32'h0);
    #3 reset = 1'b1;
    tick();
    check("t7_req_post", {31'b0, exc_req}, 32'h0);
    check("t7_pend_post", {31'b0, pend},   32'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
